// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
//
// Sequencing stage in front of an 8-bit combinational ALU. It accepts one
// operation at a time, registers the operands and select into the ALU, then
// captures the 9-bit ALU answer and presents a 16-bit result with status
// flags. It computes multiply (opcode 4'b0010) itself with an 8-cycle
// shift-add, intercepts divide-by-zero, and holds the result until the
// downstream consumes it.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. The producer keeps valid asserted and
// its data stable until that edge. Upstream ready is in_ready; downstream
// valid is out_valid.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready   operation request handshake
//   op_a, op_b, op_sel  operands and opcode (ALU encoding)
//   alu_a/alu_b/alu_sel registered operands/select driven to the ALU
//   alu_result          9-bit combinational answer from the ALU
//   out_valid/out_ready result handshake
//   result              16-bit operation result
//   carry, zero         carry/borrow/overflow flag, result == 0
//   div_zero, illegal   divide by zero, multiply while MUL_EN=0
//   ops_done            count of results taken downstream (wraps)
// ---------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter bit MUL_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic [3:0]       op_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [8:0]       alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic             carry,
  output logic             zero,
  output logic             div_zero,
  output logic             illegal,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;

  typedef enum logic [1:0] {IDLE, ISSUE, MUL, DONE} state_t;
  state_t state;

  // Shift-add multiplier: the multiplicand moves left while the multiplier
  // moves right, so bit 0 of mul_mplier always selects the current partial.
  logic [15:0] mul_acc;
  logic [15:0] mul_mcand;
  logic [7:0]  mul_mplier;
  logic [2:0]  mul_cnt;
  logic [15:0] mul_step;

  assign mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : 16'd0);

  assign in_ready = (state == IDLE);

  // Result and flags captured at the end of the ISSUE cycle.
  logic [15:0] issue_result;
  logic        issue_carry;
  logic        issue_div_zero;
  logic        issue_illegal;

  always_comb begin
    issue_result   = {7'b0, alu_result};
    issue_carry    = 1'b0;
    issue_div_zero = 1'b0;
    issue_illegal  = 1'b0;
    case (alu_sel)
      OP_ADD, OP_SUB, OP_SHL: issue_carry = alu_result[8];
      default: ;
    endcase
    // The ALU's answer for a zero divisor is meaningless; override it.
    if (alu_sel == OP_DIV && alu_b == 8'd0) begin
      issue_result   = 16'd0;
      issue_carry    = 1'b0;
      issue_div_zero = 1'b1;
    end
    // Multiply only reaches ISSUE when the internal multiplier is disabled.
    if (alu_sel == OP_MUL && !MUL_EN) begin
      issue_result  = 16'd0;
      issue_carry   = 1'b0;
      issue_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      alu_sel    <= 4'd0;
      out_valid  <= 1'b0;
      result     <= 16'd0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      div_zero   <= 1'b0;
      illegal    <= 1'b0;
      ops_done   <= '0;
      mul_acc    <= 16'd0;
      mul_mcand  <= 16'd0;
      mul_mplier <= 8'd0;
      mul_cnt    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a      <= op_a;
            alu_b      <= op_b;
            alu_sel    <= op_sel;
            mul_acc    <= 16'd0;
            mul_mcand  <= {8'd0, op_a};
            mul_mplier <= op_b;
            mul_cnt    <= 3'd0;
            state      <= (op_sel == OP_MUL && MUL_EN) ? MUL : ISSUE;
          end
        end
        ISSUE: begin
          result    <= issue_result;
          carry     <= issue_carry;
          zero      <= (issue_result == 16'd0);
          div_zero  <= issue_div_zero;
          illegal   <= issue_illegal;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        MUL: begin
          mul_acc    <= mul_step;
          mul_mcand  <= {mul_mcand[14:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[7:1]};
          mul_cnt    <= mul_cnt + 3'd1;
          if (mul_cnt == 3'd7) begin
            result    <= mul_step;
            carry     <= |mul_step[15:8];
            zero      <= (mul_step == 16'd0);
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
            ops_done  <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_ctrl
//
// Bench for alu_exec_ctrl with a small behavioural ALU stub on the alu_*
// side. Directed vectors with hand-computed results are applied from a
// table; backpressure and reset-during-multiply are hand-written sequences.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_exec_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  op_a, op_b, alu_a, alu_b;
  logic [3:0]  op_sel, alu_sel;
  logic [8:0]  alu_result;
  logic [15:0] result, ops_done;
  logic        carry, zero, div_zero, illegal;

  alu_exec_ctrl #(.MUL_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero),
    .div_zero(div_zero), .illegal(illegal),
    .ops_done(ops_done)
  );

  // Behavioural ALU stub. Multiply and divide-by-zero deliberately return
  // junk so that the block's override of those answers is visible.
  always_comb begin
    case (alu_sel)
      4'h0:    alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1:    alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      4'h2:    alu_result = 9'h1AA;
      4'h3:    alu_result = (alu_b == 8'd0) ? 9'h1FF : {1'b0, alu_a / alu_b};
      4'h4:    alu_result = {alu_a, 1'b0};
      4'h5:    alu_result = {1'b0, alu_a & alu_b};
      default: alu_result = {1'b1, ~alu_a};
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int exp_ops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  sel;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        dz;
    logic        ill;
    int          lat;
  } vec_t;

  // ---------------- driver tasks ----------------
  // Apply one operation with out_ready low, wait for the result, check it,
  // then complete the output handshake.
  task automatic do_op(input vec_t v);
    int t0;
    int n;
    logic [15:0] e;
    @(negedge clk);
    chk({v.name, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; op_a = v.a; op_b = v.b; op_sel = v.sel;
    t0 = cyc;
    exp_q.push_back(v.res);
    @(negedge clk);
    // Scramble the request bus: the block must not track it after accept.
    in_valid = 1'b0;
    op_a = 8'($urandom_range(0, 255));
    op_b = 8'($urandom_range(0, 255));
    op_sel = 4'($urandom_range(0, 15));
    chk({v.name, "_alu_a"}, alu_a, v.a);
    chk({v.name, "_alu_b"}, alu_b, v.b);
    chk({v.name, "_alu_sel"}, alu_sel, v.sel);
    n = 0;
    while (!out_valid && n < 20) begin
      chk({v.name, "_busy_ready"}, in_ready, 0);
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    if (!out_valid) begin
      chk({v.name, "_timeout"}, 0, 1);
    end else begin
      chk({v.name, "_latency"}, cyc - t0, v.lat);
      chk({v.name, "_result"}, result, e);
      chk({v.name, "_carry"}, carry, v.c);
      chk({v.name, "_zero"}, zero, v.z);
      chk({v.name, "_div_zero"}, div_zero, v.dz);
      chk({v.name, "_illegal"}, illegal, v.ill);
      chk({v.name, "_done_ready"}, in_ready, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_ops++;
      chk({v.name, "_valid_drop"}, out_valid, 0);
      chk({v.name, "_ops_done"}, ops_done, 16'(exp_ops));
      chk({v.name, "_dz_clear"}, div_zero, 0);
      chk({v.name, "_ill_clear"}, illegal, 0);
      chk({v.name, "_result_hold"}, result, e);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[14];

  initial begin
    int t0;
    int n;
    in_valid = 1'b0; out_ready = 1'b0;
    op_a = 8'd0; op_b = 8'd0; op_sel = 4'd0;

    vecs[0]  = '{"add_200_100", 8'd200, 8'd100, 4'h0, 16'h012C, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{"sub_3_5",     8'd3,   8'd5,   4'h1, 16'h01FE, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[2]  = '{"sub_5_5",     8'd5,   8'd5,   4'h1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[3]  = '{"mul_255_255", 8'd255, 8'd255, 4'h2, 16'hFE01, 1'b1, 1'b0, 1'b0, 1'b0, 9};
    vecs[4]  = '{"mul_12_10",   8'd12,  8'd10,  4'h2, 16'h0078, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vecs[5]  = '{"div_10_0",    8'd10,  8'd0,   4'h3, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[6]  = '{"div_10_3",    8'd10,  8'd3,   4'h3, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[7]  = '{"shl_81",      8'h81,  8'd0,   4'h4, 16'h0102, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{"and_f0_0f",   8'hF0,  8'h0F,  4'h5, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[9]  = '{"rsv_f_0f",    8'h0F,  8'h00,  4'hF, 16'h01F0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{"mul_0_7",     8'd0,   8'd7,   4'h2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9};
    vecs[11] = '{"mul_16_16",   8'd16,  8'd16,  4'h2, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 9};
    vecs[12] = '{"mul_1_255",   8'd1,   8'd255, 4'h2, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vecs[13] = '{"add_0_0",     8'd0,   8'd0,   4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2};

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, div_zero, illegal}, 0);
    chk("rst_alu_bus", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_ops_done", ops_done, 0);

    // Reset asserted in the 4th multiply cycle
    @(negedge clk);
    in_valid = 1'b1; op_a = 8'd7; op_b = 8'd9; op_sel = 4'h2;
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t0 + 4) @(negedge clk);
    chk("mulrst_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mulrst_in_ready", in_ready, 1);
    chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_result", result, 0);
    chk("mulrst_ops_done", ops_done, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("mulrst_no_pulse", n, 0);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) do_op(vecs[i]);

    // Backpressure on 1+1 with a competing request while busy
    @(negedge clk);
    in_valid = 1'b1; op_a = 8'd1; op_b = 8'd1; op_sel = 4'h0;
    @(negedge clk);
    op_a = 8'd9; op_b = 8'd4; op_sel = 4'h1;   // held request, must be ignored
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 16'h0002);
      chk("bp_alu_bus", {alu_a, alu_b, alu_sel}, {8'd1, 8'd1, 4'h0});
      chk("bp_in_ready", in_ready, 0);
      chk("bp_ops_done", ops_done, 16'(exp_ops));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_ops++;
    chk("bp_ops_done_inc", ops_done, 16'(exp_ops));
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("bp_single_handshake", ops_done, 16'(exp_ops));
    chk("bp_no_new_op", out_valid, 0);
    chk("bp_alu_a_kept", alu_a, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Sequencing stage directly upstream of the 8-bit combinational ALU.
- Accepts one operation at a time over a valid/ready handshake and registers the operands and select code into the ALU.
- Captures the ALU's 9-bit result and returns a 16-bit result with status flags downstream.
- Implements opcode 4'b0010 (multiply) itself as an 8-cycle shift-add, intercepts divide-by-zero, and holds the result until consumed.

Parameters:
- MUL_EN, 1: 1 enables the internal multiplier; 0 makes opcode 4'b0010 return result 0 with illegal=1.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation.
- op_a  input  8  operand A.
- op_b  input  8  operand B.
- op_sel  input  4  opcode, same encoding as the ALU.
- alu_a  output  8  registered operand A driven to the ALU.
- alu_b  output  8  registered operand B driven to the ALU.
- alu_sel  output  4  registered select driven to the ALU.
- alu_result  input  9  combinational result returned from the ALU.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- result  output  16  operation result.
- carry  output  1  carry/borrow/overflow flag.
- zero  output  1  result == 0.
- div_zero  output  1  division attempted with B == 0.
- illegal  output  1  multiply requested with MUL_EN=0.
- ops_done  output  CNT_W  count of results accepted downstream; wraps.

Behaviour:
- Reset:
  - State IDLE; in_ready=1.
  - out_valid, carry, zero, div_zero and illegal = 0.
  - result, alu_a, alu_b, alu_sel and ops_done = 0.
  - Multiplier registers cleared.
- Reset mid-operation: any in-flight operation is discarded, no output is produced, and the block is IDLE on the next cycle.
- in_ready = (state == IDLE). An operation is accepted on a cycle where in_valid && in_ready.
- FSM states: IDLE, ISSUE, MUL, DONE.
- IDLE:
  - On accept, latch op_a, op_b, op_sel into alu_a, alu_b, alu_sel.
  - Go to MUL if op_sel == 4'b0010 and MUL_EN=1; otherwise go to ISSUE.
- ISSUE (exactly 1 cycle): sample alu_result at the end of the cycle, compute result and flags, go to DONE.
- MUL (exactly 8 cycles):
  - Shift-add over the bits of B, LSB first, into a 16-bit product.
  - After the 8th cycle, result = product; go to DONE.
  - alu_sel is still driven as 4'b0010 and alu_result is ignored.
- DONE:
  - out_valid=1; result and flags are stable.
  - When out_ready=1: go to IDLE, out_valid drops next cycle, ops_done increments.
  - New requests are not accepted in the same cycle.
- Latency, with the accept cycle as T:
  - ALU operations: out_valid at T+2.
  - Multiply: out_valid at T+9.
  - Throughput is at most 1 operation per 3 cycles with out_ready held high.
- Result width: for ALU operations, result = {7'b0, alu_result}; for multiply, result = full 16-bit product.
- carry:
  - alu_result[8] for opcodes 0000 (add carry), 0001 (borrow) and 0100 (shifted-out bit).
  - |product[15:8] for multiply.
  - 0 for all other opcodes.
- zero = (result == 16'd0); evaluated for every opcode, including the overridden cases below.
- Divide by zero (op_sel == 4'b0011, B == 0): alu_result is ignored; result=0, div_zero=1, zero=1, carry=0.
- Multiply with MUL_EN=0: handled through the ISSUE path with result=0, illegal=1, zero=1.
- div_zero and illegal are valid only while out_valid=1 and clear on the transition to IDLE.
- Reserved opcodes behave as the ALU defines; this block adds no opcode checks beyond those above.
- alu_a, alu_b and alu_sel hold their values from accept until the next accept; they do not return to 0 in IDLE.
- ops_done wraps from all-ones to 0 without a flag.
- in_valid while in_ready=0 is ignored. The upstream must hold the request, since the data is not sampled.

Test Plan:
- Add 200+100 (op_sel=0000), out_ready=1 → out_valid at T+2, result=0x012C, carry=1, zero=0; ops_done=1 one cycle later.
- Subtract 3-5 (0001) → result=0x01FE, carry=1; then 5-5 → result=0x0000, zero=1, carry=0.
- Multiply 255*255 (0010, MUL_EN=1) → in_ready low T+1..T+9, out_valid at T+9, result=0xFE01, carry=1. Also check 12*10 → 0x0078, carry=0.
- Divide 10/0 (0011) → result=0, div_zero=1, zero=1. Then 10/3 → result=0x0003, div_zero=0.
- Backpressure on add 1+1: out_ready held low 5 cycles → out_valid, result=0x0002 and alu_* stable; in_ready=0 and a concurrent in_valid is ignored. Releasing out_ready gives exactly one handshake, ops_done +1.
- Reset asserted in MUL cycle 4 → next cycle state IDLE, in_ready=1, out_valid=0, result=0, ops_done unchanged at 0; no out_valid pulse afterwards.
